// File: rtl/mm2s_arb_pkg.sv
// mm2s_arb_pkg: shared types and constants for the MM2S stream arbiter.
//   arb_state_e     : arbiter FSM state (IDLE / GNT0 / GNT1)
//   GRANT_*         : one-hot grant encodings presented on o_grant
//   STAT_CNT_W      : width of the per-channel packet/beat counters
//   ABORT_CNT_W     : width of the saturating watchdog-abort counter
package mm2s_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CH0  = 2'b01;
  localparam logic [1:0] GRANT_CH1  = 2'b10;

  localparam int unsigned STAT_CNT_W  = 32;
  localparam int unsigned ABORT_CNT_W = 16;

  function automatic logic [1:0] state_to_grant(input arb_state_e st);
    logic [1:0] g;
    g = GRANT_NONE;
    unique case (st)
      GNT0:    g = GRANT_CH0;
      GNT1:    g = GRANT_CH1;
      default: g = GRANT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mm2s_arb_stats.sv
// mm2s_arb_stats: per-channel beat and packet counters (wrap modulo 2^32).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   beat      : one accepted beat of this channel this cycle
//   pkt       : the accepted beat carried tlast
//   beat_cnt  : beats transferred
//   pkt_cnt   : packets completed
module mm2s_arb_stats
  import mm2s_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  beat,
  input  logic                  pkt,
  output logic [STAT_CNT_W-1:0] beat_cnt,
  output logic [STAT_CNT_W-1:0] pkt_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (beat) beat_cnt <= beat_cnt + STAT_CNT_W'(1);
      if (pkt)  pkt_cnt  <= pkt_cnt + STAT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/mm2s_stream_arbiter.sv
// mm2s_stream_arbiter: packet-granular round-robin arbiter merging two AXI4-Stream
// MM2S channels onto one checker stream, with a stall watchdog.
// Ports:
//   AXI_CLk, AXI_RST        : clock, asynchronous active-high reset
//   i_ch_en[1:0]            : per-channel enable (gates new grants only)
//   S0_AXIS_*, S1_AXIS_*    : channel input streams
//   M_AXIS_*                : merged output stream (combinational pass-through)
//   o_grant                 : one-hot grant, 00 when idle
//   o_err_timeout           : sticky watchdog-abort flag
//   o_abort_cnt             : saturating watchdog-abort count
//   o_pkt_cnt0/1, o_beat_cnt0/1 : per-channel stats, zero unless MM2S_ARB_STATS_EN
// Build option: define MM2S_ARB_STATS_EN to synthesize the statistics counters.
module mm2s_stream_arbiter
  import mm2s_arb_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned KEEP_W      = DATA_W / 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                   AXI_CLk,
  input  logic                   AXI_RST,
  input  logic [1:0]             i_ch_en,
  input  logic [DATA_W-1:0]      S0_AXIS_tdata,
  input  logic [KEEP_W-1:0]      S0_AXIS_tkeep,
  input  logic                   S0_AXIS_tlast,
  input  logic                   S0_AXIS_tvalid,
  output logic                   S0_AXIS_tready,
  input  logic [DATA_W-1:0]      S1_AXIS_tdata,
  input  logic [KEEP_W-1:0]      S1_AXIS_tkeep,
  input  logic                   S1_AXIS_tlast,
  input  logic                   S1_AXIS_tvalid,
  output logic                   S1_AXIS_tready,
  output logic [DATA_W-1:0]      M_AXIS_tdata,
  output logic [KEEP_W-1:0]      M_AXIS_tkeep,
  output logic                   M_AXIS_tlast,
  output logic                   M_AXIS_tvalid,
  input  logic                   M_AXIS_tready,
  output logic [1:0]             o_grant,
  output logic                   o_err_timeout,
  output logic [ABORT_CNT_W-1:0] o_abort_cnt,
  output logic [STAT_CNT_W-1:0]  o_pkt_cnt0,
  output logic [STAT_CNT_W-1:0]  o_pkt_cnt1,
  output logic [STAT_CNT_W-1:0]  o_beat_cnt0,
  output logic [STAT_CNT_W-1:0]  o_beat_cnt1
);

  localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  arb_state_e             state_q, state_d;
  logic                   last_gnt_q, last_gnt_d;  // channel index served last
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   err_q;
  logic [ABORT_CNT_W-1:0] abort_q;
  logic [1:0]             req;
  logic                   hs;
  logic                   abort;
  logic                   cur;

  assign req = {S1_AXIS_tvalid & i_ch_en[1], S0_AXIS_tvalid & i_ch_en[0]};
  assign hs  = M_AXIS_tvalid & M_AXIS_tready;

  // Zero-latency data mux; the non-granted channel is always back-pressured.
  always_comb begin
    M_AXIS_tdata   = '0;
    M_AXIS_tkeep   = '0;
    M_AXIS_tlast   = 1'b0;
    M_AXIS_tvalid  = 1'b0;
    S0_AXIS_tready = 1'b0;
    S1_AXIS_tready = 1'b0;
    unique case (state_q)
      GNT0: begin
        M_AXIS_tdata   = S0_AXIS_tdata;
        M_AXIS_tkeep   = S0_AXIS_tkeep;
        M_AXIS_tlast   = S0_AXIS_tlast;
        M_AXIS_tvalid  = S0_AXIS_tvalid;
        S0_AXIS_tready = M_AXIS_tready;
      end
      GNT1: begin
        M_AXIS_tdata   = S1_AXIS_tdata;
        M_AXIS_tkeep   = S1_AXIS_tkeep;
        M_AXIS_tlast   = S1_AXIS_tlast;
        M_AXIS_tvalid  = S1_AXIS_tvalid;
        S1_AXIS_tready = M_AXIS_tready;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    abort      = 1'b0;
    cur        = (state_q == GNT1);
    unique case (state_q)
      IDLE: begin
        if (req == 2'b11)  state_d = last_gnt_q ? GNT0 : GNT1;
        else if (req[0])   state_d = GNT0;
        else if (req[1])   state_d = GNT1;
      end
      GNT0, GNT1: begin
        if (hs && M_AXIS_tlast) begin
          // Re-arbitrate in the tlast cycle so packets of different channels abut.
          last_gnt_d = cur;
          if (req[~cur])     state_d = cur ? GNT0 : GNT1;
          else if (req[cur]) state_d = state_q;
          else               state_d = IDLE;
        end else if (!hs && (wd_q == WD_LAST)) begin
          abort      = 1'b1;
          last_gnt_d = cur;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Watchdog counts cycles without progress inside a single grant.
    if ((state_q == IDLE) || hs || (state_d != state_q)) wd_d = '0;
    else                                                  wd_d = wd_q + WD_W'(1);
  end

  always_ff @(posedge AXI_CLk or posedge AXI_RST) begin
    if (AXI_RST) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      wd_q       <= '0;
      err_q      <= 1'b0;
      abort_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      wd_q       <= wd_d;
      if (abort) begin
        err_q <= 1'b1;
        if (abort_q != '1) abort_q <= abort_q + ABORT_CNT_W'(1);
      end
    end
  end

  assign o_grant       = state_to_grant(state_q);
  assign o_err_timeout = err_q;
  assign o_abort_cnt   = abort_q;

`ifdef MM2S_ARB_STATS_EN
  logic beat0, beat1;
  assign beat0 = hs & (state_q == GNT0);
  assign beat1 = hs & (state_q == GNT1);

  mm2s_arb_stats u_stats0 (
    .clk      (AXI_CLk),
    .rst      (AXI_RST),
    .beat     (beat0),
    .pkt      (beat0 & M_AXIS_tlast),
    .beat_cnt (o_beat_cnt0),
    .pkt_cnt  (o_pkt_cnt0)
  );

  mm2s_arb_stats u_stats1 (
    .clk      (AXI_CLk),
    .rst      (AXI_RST),
    .beat     (beat1),
    .pkt      (beat1 & M_AXIS_tlast),
    .beat_cnt (o_beat_cnt1),
    .pkt_cnt  (o_pkt_cnt1)
  );
`else
  assign o_pkt_cnt0  = '0;
  assign o_pkt_cnt1  = '0;
  assign o_beat_cnt0 = '0;
  assign o_beat_cnt1 = '0;
`endif

endmodule

// File: tb/tb_mm2s_stream_arbiter.sv
// tb_mm2s_stream_arbiter: directed self-checking bench for mm2s_stream_arbiter
// (TIMEOUT_CYC = 16). Stats expectations follow MM2S_ARB_STATS_EN.
module tb_mm2s_stream_arbiter;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned KEEP_W = 8;
  localparam int unsigned TIMEOUT_CYC = 16;
`ifdef MM2S_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        ch_en;
  logic [DATA_W-1:0] s0_tdata, s1_tdata, m_tdata;
  logic [KEEP_W-1:0] s0_tkeep, s1_tkeep, m_tkeep;
  logic              s0_tlast, s0_tvalid, s0_tready;
  logic              s1_tlast, s1_tvalid, s1_tready;
  logic              m_tlast, m_tvalid, m_tready;
  logic [1:0]        grant;
  logic              err_timeout;
  logic [15:0]       abort_cnt;
  logic [31:0]       pkt_cnt0, pkt_cnt1, beat_cnt0, beat_cnt1;

  int errors = 0;
  int checks = 0;
  int k0, k1, exp_ch;

  always #5 clk = ~clk;

  mm2s_stream_arbiter #(
    .DATA_W      (DATA_W),
    .KEEP_W      (KEEP_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .AXI_CLk        (clk),
    .AXI_RST        (rst),
    .i_ch_en        (ch_en),
    .S0_AXIS_tdata  (s0_tdata),
    .S0_AXIS_tkeep  (s0_tkeep),
    .S0_AXIS_tlast  (s0_tlast),
    .S0_AXIS_tvalid (s0_tvalid),
    .S0_AXIS_tready (s0_tready),
    .S1_AXIS_tdata  (s1_tdata),
    .S1_AXIS_tkeep  (s1_tkeep),
    .S1_AXIS_tlast  (s1_tlast),
    .S1_AXIS_tvalid (s1_tvalid),
    .S1_AXIS_tready (s1_tready),
    .M_AXIS_tdata   (m_tdata),
    .M_AXIS_tkeep   (m_tkeep),
    .M_AXIS_tlast   (m_tlast),
    .M_AXIS_tvalid  (m_tvalid),
    .M_AXIS_tready  (m_tready),
    .o_grant        (grant),
    .o_err_timeout  (err_timeout),
    .o_abort_cnt    (abort_cnt),
    .o_pkt_cnt0     (pkt_cnt0),
    .o_pkt_cnt1     (pkt_cnt1),
    .o_beat_cnt0    (beat_cnt0),
    .o_beat_cnt1    (beat_cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    s0_tdata = '0; s0_tkeep = 8'hFF; s0_tlast = 1'b0; s0_tvalid = 1'b0;
    s1_tdata = '0; s1_tkeep = 8'h0F; s1_tlast = 1'b0; s1_tvalid = 1'b0;
    ch_en = 2'b11;
    m_tready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    // Reset state
    idle_inputs();
    rst = 1'b1;
    #3;
    chk("rst_grant", grant, 2'b00);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s0_tready", s0_tready, 0);
    chk("rst_s1_tready", s1_tready, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_abort", abort_cnt, 0);
    chk("rst_pkt0", pkt_cnt0, 0);
    chk("rst_beat0", beat_cnt0, 0);
    tick();
    rst = 1'b0;

    // Ch0 only: 3 packets x 8 beats
    s0_tvalid = 1'b1; s0_tdata = 64'h100; settle();
    chk("lat_idle_grant", grant, 2'b00);
    chk("lat_idle_tvalid", m_tvalid, 0);
    tick();
    for (int k = 0; k < 24; k++) begin
      s0_tdata = 64'h100 + 64'(k);
      s0_tlast = (k % 8 == 7);
      settle();
      chk($sformatf("c0_grant%0d", k), grant, 2'b01);
      chk($sformatf("c0_data%0d", k), m_tdata, 64'h100 + 64'(k));
      if (k % 8 == 7) chk($sformatf("c0_last%0d", k), m_tlast, 1);
      tick();
    end
    s0_tvalid = 1'b0; s0_tlast = 1'b0; settle();
    chk("c0_keep", m_tkeep, 8'hFF);
    chk("c0_s1_tready", s1_tready, 0);
    chk("c0_pkt_cnt0", pkt_cnt0, STATS ? 3 : 0);
    chk("c0_beat_cnt0", beat_cnt0, STATS ? 24 : 0);
    chk("c0_beat_cnt1", beat_cnt1, 0);

    // Both request continuously, 4-beat packets: 0,1,0,1 with no bubbles
    do_reset();
    k0 = 0; k1 = 0;
    s0_tvalid = 1'b1; s1_tvalid = 1'b1;
    s0_tdata = 64'hA000; s1_tdata = 64'hB000;
    settle();
    chk("rr_idle_grant", grant, 2'b00);
    tick();
    for (int i = 0; i < 16; i++) begin
      s0_tdata = 64'hA000 + 64'(k0); s0_tlast = (k0 % 4 == 3);
      s1_tdata = 64'hB000 + 64'(k1); s1_tlast = (k1 % 4 == 3);
      settle();
      exp_ch = (i / 4) % 2;
      chk($sformatf("rr_grant%0d", i), grant, (exp_ch == 1) ? 2'b10 : 2'b01);
      chk($sformatf("rr_data%0d", i), m_tdata,
          (exp_ch == 1) ? 64'hB000 + 64'(k1) : 64'hA000 + 64'(k0));
      if (exp_ch == 1) k1++;
      else k0++;
      tick();
    end
    settle();
    chk("rr_keep_ch0", m_tkeep, 8'hFF);
    chk("rr_beat_cnt1", beat_cnt1, STATS ? 8 : 0);
    chk("rr_pkt_cnt1", pkt_cnt1, STATS ? 2 : 0);

    // Ch1 enable dropped mid-packet: packet completes, then only ch0 served
    do_reset();
    s1_tvalid = 1'b1; settle(); tick();
    for (int k = 0; k < 5; k++) begin
      s1_tdata = 64'hC000 + 64'(k);
      s1_tlast = (k == 4);
      if (k == 2) begin
        ch_en = 2'b01;
        s0_tvalid = 1'b1;
      end
      settle();
      chk($sformatf("en_c1_grant%0d", k), grant, 2'b10);
      chk($sformatf("en_c1_data%0d", k), m_tdata, 64'hC000 + 64'(k));
      tick();
    end
    s1_tlast = 1'b0; s1_tdata = 64'hC100;
    for (int k = 0; k < 8; k++) begin
      s0_tdata = 64'hD000 + 64'(k);
      s0_tlast = (k % 4 == 3);
      settle();
      chk($sformatf("en_c0_grant%0d", k), grant, 2'b01);
      chk($sformatf("en_c0_data%0d", k), m_tdata, 64'hD000 + 64'(k));
      tick();
    end

    // Watchdog: ch0 stalls after 3 beats, ch1 pending
    do_reset();
    s0_tvalid = 1'b1; s1_tvalid = 1'b1;
    s1_tdata = 64'hE000; s1_tlast = 1'b1;
    settle(); tick();
    for (int k = 0; k < 3; k++) begin
      s0_tdata = 64'hF000 + 64'(k);
      settle();
      chk($sformatf("wd_data%0d", k), m_tdata, 64'hF000 + 64'(k));
      tick();
    end
    s0_tvalid = 1'b0;
    for (int s = 1; s <= 16; s++) begin
      settle();
      chk($sformatf("wd_stall_grant%0d", s), grant, 2'b01);
      if (s == 16) chk("wd_err_before", err_timeout, 0);
      tick();
    end
    settle();
    chk("wd_idle_grant", grant, 2'b00);
    chk("wd_idle_tvalid", m_tvalid, 0);
    chk("wd_err", err_timeout, 1);
    chk("wd_abort_cnt", abort_cnt, 1);
    tick(); settle();
    chk("wd_next_grant", grant, 2'b10);
    chk("wd_next_data", m_tdata, 64'hE000);
    chk("wd_next_last", m_tlast, 1);

    // Back-pressure for 10 cycles, below the timeout
    do_reset();
    s0_tvalid = 1'b1; s0_tdata = 64'h5000;
    settle(); tick();
    settle();
    chk("bp_beat0", m_tdata, 64'h5000);
    tick();
    m_tready = 1'b0; s0_tdata = 64'h5001;
    for (int c = 0; c < 10; c++) begin
      settle();
      chk($sformatf("bp_hold_data%0d", c), m_tdata, 64'h5001);
      chk($sformatf("bp_hold_rdy%0d", c), s0_tready, 0);
      tick();
    end
    m_tready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      s0_tdata = 64'h5000 + 64'(k);
      s0_tlast = (k == 3);
      settle();
      chk($sformatf("bp_grant%0d", k), grant, 2'b01);
      chk($sformatf("bp_data%0d", k), m_tdata, 64'h5000 + 64'(k));
      tick();
    end
    s0_tvalid = 1'b0; s0_tlast = 1'b0; settle();
    chk("bp_err", err_timeout, 0);
    chk("bp_abort", abort_cnt, 0);
    chk("bp_beat_cnt0", beat_cnt0, STATS ? 4 : 0);
    chk("bp_pkt_cnt0", pkt_cnt0, STATS ? 1 : 0);

    // Reset mid-packet; afterwards ch0 wins the first tie again
    do_reset();
    s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tdata = 64'h6000;
    s1_tvalid = 1'b1; s1_tlast = 1'b0; s1_tdata = 64'h7000;
    settle(); tick();
    settle();
    chk("mr_grant_c0", grant, 2'b01);
    tick();
    settle();
    chk("mr_grant_c1", grant, 2'b10);
    chk("mr_data_c1", m_tdata, 64'h7000);
    tick();
    s1_tdata = 64'h7001; settle();
    rst = 1'b1; settle();
    chk("mr_rst_grant", grant, 2'b00);
    chk("mr_rst_tvalid", m_tvalid, 0);
    chk("mr_rst_s0_tready", s0_tready, 0);
    chk("mr_rst_s1_tready", s1_tready, 0);
    chk("mr_rst_beat1", beat_cnt1, 0);
    tick();
    rst = 1'b0; settle();
    chk("mr_rel_grant", grant, 2'b00);
    tick(); settle();
    chk("mr_tie_grant", grant, 2'b01);
    chk("mr_tie_data", m_tdata, 64'h6000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mm2s_stream_arbiter.md
# mm2s_stream_arbiter

Packet-granular round-robin arbiter that shares the single MM2S data-check/rate-measurement path between two AXI4-Stream MM2S DMA channels. Sits between the DMA stream outputs and the checker FIFO input, holding grant for a whole packet (up to `tlast`), with a stall watchdog that frees the path if a granted channel hangs mid-packet. Optional per-channel packet/beat statistics feed the ILA/status registers.

## Interface
- `DATA_W`, 64: stream data width.
- `KEEP_W`, DATA_W/8: tkeep width.
- `TIMEOUT_CYC`, 1024: cycles without a handshake, while granted, before abort.
- `AXI_CLk` in 1: single clock for all logic.
- `AXI_RST` in 1: reset, asynchronous, active-high.
- `i_ch_en` in 2: per-channel enable; gates new grants only.
- `S0_AXIS_tdata/tkeep/tlast/tvalid` in DATA_W/KEEP_W/1/1: channel 0 stream in.
- `S0_AXIS_tready` out 1: channel 0 ready.
- `S1_AXIS_*`: identical set for channel 1.
- `M_AXIS_tdata/tkeep/tlast/tvalid` out DATA_W/KEEP_W/1/1: merged stream to checker.
- `M_AXIS_tready` in 1: checker ready (FIFO not full).
- `o_grant` out 2: one-hot current grant, 00 when idle.
- `o_err_timeout` out 1: sticky, set on any watchdog abort.
- `o_abort_cnt` out 16: saturating count of watchdog aborts.
- `o_pkt_cnt0/1` out 32: packets completed per channel (stats build only).
- `o_beat_cnt0/1` out 32: beats transferred per channel (stats build only).

## Operation
- States: IDLE, GNT0, GNT1. Request `req[x] = Sx_tvalid & i_ch_en[x]`.
- IDLE: if both request, grant channel != `last_gnt`; else grant the requester; none -> stay. `last_gnt` resets to 1 (channel 0 wins first tie).
- GNTx: data path combinational mux: `M_* = Sx_*`, `Sx_tready = M_AXIS_tready`; other channel tready = 0. In IDLE, `M_AXIS_tvalid = 0`, both treadys 0.
- Release: on handshake (`tvalid & tready`) with `tlast`. Same cycle, next state chosen from current `req` with the just-served channel lowest priority; no request -> IDLE. `last_gnt` updated to served channel. No bubble between back-to-back packets of different channels.
- Deassert of `i_ch_en[x]` mid-packet: packet completes normally; only future grants blocked.
- Watchdog: counter clears on each handshake and on grant change; increments in GNTx otherwise. Reaching `TIMEOUT_CYC-1` -> next state IDLE, `o_err_timeout` set, `o_abort_cnt` +1 (saturate at 0xFFFF), `last_gnt` = aborted channel. Stall caused by `M_AXIS_tready=0` also counts.
- Counters wrap modulo 2^32 (packet/beat); abort counter saturates.

## Timing
- Reset values: state IDLE, `o_grant`=00, all counters 0, `o_err_timeout`=0, `M_AXIS_tvalid`=0, all treadys 0.
- Grant latency: request seen in IDLE at cycle N -> grant and pass-through at N+1.
- Data latency through arbiter: 0 cycles while granted.
- Abort: first cycle of IDLE is `TIMEOUT_CYC` cycles after last handshake/grant start.
- Reset mid-packet: immediate return to IDLE; partial packet is the checker's concern.

## Configuration
- `MM2S_ARB_STATS_EN` defined: `o_pkt_cnt0/1`, `o_beat_cnt0/1` live, incremented on handshake (beat) and tlast handshake (packet) of the granted channel.
- Not defined: counters not synthesized, those outputs tied to 0; arbitration and watchdog unchanged.

## Structure
- Package `mm2s_arb_pkg`: state enum (IDLE/GNT0/GNT1), grant encoding constants, counter widths (32, 16).
- Sub-module `mm2s_arb_stats`: one per channel, beat/packet counters, instantiated only under `MM2S_ARB_STATS_EN`.

## Test plan
- Ch0 only, 3 packets × 8 beats, tready=1 -> grant 01 throughout, output beats identical and ordered, pkt_cnt0=3, beat_cnt0=24.
- Both request continuously, 4-beat packets -> grants alternate 0,1,0,1 with zero idle cycles between tlast and next beat.
- Ch1 mid-packet (beat 2 of 5), `i_ch_en[1]` cleared -> remaining 3 beats pass, then ch1 never granted while ch0 served.
- Granted ch0 stops tvalid after beat 3, `TIMEOUT_CYC`=16 -> IDLE after 16 stalled cycles, `o_err_timeout`=1, abort_cnt=1, pending ch1 granted next.
- `M_AXIS_tready` held 0 for 10 cycles (< timeout) mid-packet -> no abort, data held stable, transfer resumes.
- Assert `AXI_RST` mid-packet -> same cycle all outputs at reset values; after release, ch0 wins first tie.
